// File: rtl/ccff_pkg.sv
// Shared types and width helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ccff_ld_state_e;

  function automatic int ccff_bits_left_w(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Parallel-in serial-out word register feeding the chain head, LSB first.
module ccff_piso
  import ccff_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] d,
  output logic              lsb
);

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge prog_clk) begin
    if (load) begin
      shreg <= d;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WORD_W-1:1]};
    end
  end

  assign lsb = shreg[0];

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto a configuration chain and gates its shift clock.
// Optional readback of the old chain contents: define CCFF_LOADER_READBACK_EN.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rd_word,
  output logic              rd_valid,
  output logic              busy,
  output logic              done
);

  localparam int BL_W  = ccff_bits_left_w(CHAIN_LEN);
  localparam int CNT_W = $clog2(WORD_W + 1);

  ccff_ld_state_e   state;
  logic [BL_W-1:0]  bits_left;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             shifting;
  logic             last_bit;
  logic             shreg_lsb;

  assign accept    = (state == ST_LOAD) && word_valid;
  assign shifting  = (state == ST_SHIFT);
  assign last_bit  = shifting && (cnt == CNT_W'(1));
  assign ccff_head = ccff_clk_en & shreg_lsb;

  ccff_piso #(.WORD_W(WORD_W)) u_piso (
    .prog_clk (prog_clk),
    .load     (accept),
    .shift    (shifting),
    .d        (word_in),
    .lsb      (shreg_lsb)
  );

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state       <= ST_IDLE;
      bits_left   <= '0;
      cnt         <= '0;
      word_ready  <= 1'b0;
      ccff_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bits_left  <= BL_W'(CHAIN_LEN);
            state      <= ST_LOAD;
            word_ready <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (word_valid) begin
            // The final word may carry fewer live bits than WORD_W.
            if (int'(bits_left) < WORD_W) cnt <= CNT_W'(bits_left);
            else                          cnt <= CNT_W'(WORD_W);
            state       <= ST_SHIFT;
            word_ready  <= 1'b0;
            ccff_clk_en <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt       <= cnt - 1'b1;
          bits_left <= bits_left - 1'b1;
          if (cnt == CNT_W'(1)) begin
            ccff_clk_en <= 1'b0;
            if (bits_left == BL_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state      <= ST_LOAD;
              word_ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CCFF_LOADER_READBACK_EN
  logic [WORD_W-1:0] rd_acc;
  logic [WORD_W-1:0] rd_nxt;
  logic [CNT_W-1:0]  rd_pos;

  assign rd_nxt = rd_acc | ({{(WORD_W-1){1'b0}}, ccff_tail} << rd_pos);

  // Packer restarts on every accepted word so readback words align with input words.
  always_ff @(posedge prog_clk) begin
    if (accept) begin
      rd_acc <= '0;
      rd_pos <= '0;
    end else if (shifting) begin
      rd_acc <= rd_nxt;
      rd_pos <= rd_pos + 1'b1;
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      rd_word  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= last_bit;
      if (last_bit) rd_word <= rd_nxt;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign rd_word     = '0;
  assign rd_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: per-cycle schedule model plus a chain model.
module tb_ccff_chain_loader;

  localparam int W = 8;
`ifdef CCFF_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, start_a, start_b, valid;
  logic [W-1:0] word;
  logic a_ready, a_head, a_en, a_tail, a_rdv, a_busy, a_done;
  logic b_ready, b_head, b_en, b_tail, b_rdv, b_busy, b_done;
  logic [W-1:0] a_rdw, b_rdw;

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(20)) dut_a (
    .prog_clk(clk), .prog_reset_n(rstn), .start(start_a), .word_in(word),
    .word_valid(valid), .word_ready(a_ready), .ccff_head(a_head), .ccff_clk_en(a_en),
    .ccff_tail(a_tail), .rd_word(a_rdw), .rd_valid(a_rdv), .busy(a_busy), .done(a_done)
  );

  ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(8)) dut_b (
    .prog_clk(clk), .prog_reset_n(rstn), .start(start_b), .word_in(word),
    .word_valid(valid), .word_ready(b_ready), .ccff_head(b_head), .ccff_clk_en(b_en),
    .ccff_tail(b_tail), .rd_word(b_rdw), .rd_valid(b_rdv), .busy(b_busy), .done(b_done)
  );

  // Chain models: head enters at the top, the bit at index 0 leaves at the tail.
  logic [19:0] chain_a, pre_a;
  logic [7:0]  chain_b, pre_b;
  logic        pre_req;
  always @(posedge clk) begin
    if (pre_req) begin
      chain_a <= pre_a;
      chain_b <= pre_b;
    end else begin
      if (a_en) chain_a <= {a_head, chain_a[19:1]};
      if (b_en) chain_b <= {b_head, chain_b[7:1]};
    end
  end
  assign a_tail = chain_a[0];
  assign b_tail = chain_b[0];

  typedef struct {
    bit start, valid, rstn;
    logic [W-1:0] word;
  } stim_t;
  typedef struct {
    bit chk, first, ready, en, head, busy, done, rdv, rdw_chk;
    logic [W-1:0] rdw;
  } exp_t;

  stim_t stim_plan[$];
  exp_t  exp_plan[$];
  exp_t  exp_q[$];

  int total = 0;
  int bad = 0;
  bit sel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s.start = 1'b0; s.valid = 1'b0; s.rstn = 1'b1; s.word = '0;
    return s;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.chk = 1'b1; e.first = 1'b0; e.ready = 1'b0; e.en = 1'b0; e.head = 1'b0;
    e.busy = 1'b0; e.done = 1'b0; e.rdv = 1'b0; e.rdw_chk = 1'b0; e.rdw = '0;
    return e;
  endfunction

  int           b_cyc;
  int           busy_start;
  bit           pend_rd;
  logic [W-1:0] pend_val;

  task automatic push(input stim_t s, input exp_t e);
    if (b_cyc == busy_start) s.start = 1'b1;
    if (pend_rd) begin
      e.rdv     = RB;
      e.rdw_chk = 1'b1;
      e.rdw     = RB ? pend_val : '0;
      pend_rd   = 1'b0;
    end
    b_cyc++;
    stim_plan.push_back(s);
    exp_plan.push_back(e);
  endtask

  task automatic build_reset();
    stim_t s;
    exp_t e;
    b_cyc = 0; pend_rd = 1'b0; busy_start = -1;
    s = idle_stim(); s.rstn = 1'b0; e = idle_exp(); e.chk = 1'b0; e.first = 1'b1; push(s, e);
    s = idle_stim(); s.rstn = 1'b0; e = idle_exp(); e.rdw_chk = 1'b1; push(s, e);
    s = idle_stim(); e = idle_exp(); e.rdw_chk = 1'b1; push(s, e);
  endtask

  // Expected schedule of one load: start, then per word (stalls, accept, k shifts), then done.
  task automatic build_load(input int clen, input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input int nw, input int s0, input int s1,
                            input int s2, input int rst_at, input int bstart,
                            input logic [31:0] pre);
    logic [W-1:0] wl[3];
    int st[3];
    int remaining, sidx, off, k;
    logic [W-1:0] v;
    stim_t s;
    exp_t e;
    wl[0] = w0; wl[1] = w1; wl[2] = w2;
    st[0] = s0; st[1] = s1; st[2] = s2;
    remaining = clen; sidx = 0; off = 0;
    b_cyc = 0; pend_rd = 1'b0; busy_start = bstart;
    s = idle_stim(); s.start = 1'b1; e = idle_exp(); e.first = 1'b1; push(s, e);
    for (int j = 0; j < nw; j++) begin
      for (int i = 0; i < st[j]; i++) begin
        s = idle_stim(); s.word = 8'hEE; e = idle_exp(); e.ready = 1'b1; e.busy = 1'b1;
        push(s, e);
      end
      s = idle_stim(); s.valid = 1'b1; s.word = wl[j];
      e = idle_exp(); e.ready = 1'b1; e.busy = 1'b1;
      push(s, e);
      k = (remaining < W) ? remaining : W;
      v = W'((pre >> off) & ((32'd1 << k) - 32'd1));
      off += k;
      for (int b = 0; b < k; b++) begin
        s = idle_stim();
        e = idle_exp(); e.en = 1'b1; e.head = wl[j][b]; e.busy = 1'b1;
        if (sidx == rst_at) begin
          s.rstn = 1'b0;
          push(s, e);
          s = idle_stim(); e = idle_exp(); e.rdw_chk = 1'b1;
          push(s, e);
          return;
        end
        push(s, e);
        sidx++;
      end
      remaining -= k;
      pend_val = v;
      pend_rd  = 1'b1;
    end
    s = idle_stim(); e = idle_exp(); e.done = 1'b1; e.busy = 1'b1; push(s, e);
    s = idle_stim(); e = idle_exp(); push(s, e);
  endtask

  task automatic run_plan();
    stim_t s;
    while (stim_plan.size() != 0) begin
      @(posedge clk); #1;
      s = stim_plan.pop_front();
      start_a = s.start && !sel;
      start_b = s.start && sel;
      valid   = s.valid;
      word    = s.word;
      rstn    = s.rstn;
      exp_q.push_back(exp_plan.pop_front());
    end
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0; valid = 1'b0; word = '0; rstn = 1'b1;
  endtask

  task automatic preload(input logic [19:0] va, input logic [7:0] vb);
    pre_a = va; pre_b = vb; pre_req = 1'b1;
    @(posedge clk); #1;
    pre_req = 1'b0;
  endtask

  // Per-cycle comparison against the schedule, plus run statistics.
  exp_t ce;
  int cyc, edges, dones, done_cyc;
  logic [W-1:0] rd_q[$];
  logic o_ready, o_head, o_en, o_rdv, o_busy, o_done;
  logic [W-1:0] o_rdw;

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      if (ce.first) begin
        cyc = 0; edges = 0; dones = 0; done_cyc = 0;
        rd_q.delete();
      end
      cyc++;
      o_ready = sel ? b_ready : a_ready;
      o_head  = sel ? b_head  : a_head;
      o_en    = sel ? b_en    : a_en;
      o_rdv   = sel ? b_rdv   : a_rdv;
      o_busy  = sel ? b_busy  : a_busy;
      o_done  = sel ? b_done  : a_done;
      o_rdw   = sel ? b_rdw   : a_rdw;
      if (o_en) edges++;
      if (o_done) begin
        dones++;
        done_cyc = cyc;
      end
      if (o_rdv) rd_q.push_back(o_rdw);
      if (ce.chk) begin
        chk("word_ready", 32'(o_ready), 32'(ce.ready));
        chk("ccff_clk_en", 32'(o_en), 32'(ce.en));
        chk("ccff_head", 32'(o_head), 32'(ce.head));
        chk("busy", 32'(o_busy), 32'(ce.busy));
        chk("done", 32'(o_done), 32'(ce.done));
        chk("rd_valid", 32'(o_rdv), 32'(ce.rdv));
        if (ce.rdw_chk) chk("rd_word", 32'(o_rdw), 32'(ce.rdw));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start_a = 1'b0; start_b = 1'b0; valid = 1'b0; word = '0;
    pre_req = 1'b0; pre_a = '0; pre_b = '0; sel = 1'b0;

    build_reset();
    run_plan();
    @(negedge clk);
    chk("b_reset_busy", 32'(b_busy), 32'd0);
    chk("b_reset_ready", 32'(b_ready), 32'd0);
    chk("b_reset_clk_en", 32'(b_en), 32'd0);
    chk("b_reset_done", 32'(b_done), 32'd0);
    chk("b_reset_rd_word", 32'(b_rdw), 32'd0);

    // Three words, no stalls, over a chain preloaded with 0xABCDE.
    preload(20'hABCDE, 8'h00);
    build_load(20, 8'hA5, 8'h3C, 8'h0F, 3, 0, 0, 0, -1, -1, 32'hABCDE);
    run_plan();
    chk("t1_chain", 32'(chain_a), 32'hF3CA5);
    chk("t1_edges", edges, 32'd20);
    chk("t1_done_count", dones, 32'd1);
    chk("t1_done_cycle", done_cyc, 32'd25);
`ifdef CCFF_LOADER_READBACK_EN
    chk("t1_rd_count", rd_q.size(), 32'd3);
    if (rd_q.size() == 3) begin
      chk("t1_rd0", 32'(rd_q[0]), 32'hDE);
      chk("t1_rd1", 32'(rd_q[1]), 32'hBC);
      chk("t1_rd2", 32'(rd_q[2]), 32'h0A);
    end
`else
    chk("t1_rd_count", rd_q.size(), 32'd0);
`endif

    // Same load with a five-cycle host stall before the second word.
    preload(20'h12345, 8'h00);
    build_load(20, 8'hA5, 8'h3C, 8'h0F, 3, 0, 5, 0, -1, -1, 32'h12345);
    run_plan();
    chk("t2_chain", 32'(chain_a), 32'hF3CA5);
    chk("t2_edges", edges, 32'd20);
    chk("t2_done_cycle", done_cyc, 32'd30);

    // Single full word on an 8-bit chain, with start pulsed mid-shift.
    sel = 1'b1;
    preload(20'h00000, 8'h5A);
    build_load(8, 8'hFF, 8'h00, 8'h00, 1, 0, 0, 0, -1, 4, 32'h5A);
    run_plan();
    chk("t3_chain", 32'(chain_b), 32'hFF);
    chk("t3_edges", edges, 32'd8);
    chk("t3_done_count", dones, 32'd1);
    chk("t3_done_cycle", done_cyc, 32'd11);

    // Reset during the second word, then a clean full load.
    sel = 1'b0;
    preload(20'h0F0F0, 8'h00);
    build_load(20, 8'hA5, 8'h3C, 8'h0F, 3, 0, 0, 0, 10, -1, 32'h0F0F0);
    run_plan();
    chk("t4_abort_done_count", dones, 32'd0);
    build_load(20, 8'hA5, 8'h3C, 8'h0F, 3, 0, 0, 0, -1, -1, 32'(chain_a));
    run_plan();
    chk("t4_chain", 32'(chain_a), 32'hF3CA5);
    chk("t4_edges", edges, 32'd20);
    chk("t4_done_cycle", done_cyc, 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
